// File: rtl/fetch_redirect_ctrl.sv
// Instruction-fetch PC sequencer: owns the PC, issues req/ack fetches, applies branch
// redirects, and drains a fetch already in flight before sending the redirect target.
//
// state | meaning
// BOOT  | first cycle after reset, no request, redirects ignored
// REQ   | request on if_addr, correct-path fetch
// HOLD  | stalled, no request outstanding
// DRAIN | stale request still outstanding, redirect target parked in tgt
module fetch_redirect_ctrl #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             pc_sel,
  input  logic [31:0]      br_pc,
  input  logic             if_ack,
  output logic             if_req,
  output logic [PC_W-1:0]  if_addr,
  output logic             inst_valid,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             misalign_err,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {BOOT, REQ, HOLD, DRAIN} state_t;

  state_t          state;
  state_t          resume_state;
  logic [PC_W-1:0] tgt;
  logic [PC_W-1:0] tgt_a;
  logic            redirect;
  logic            unused_br_hi;

  assign tgt_a        = {br_pc[PC_W-1:2], 2'b00};
  assign unused_br_hi = ^br_pc[31:PC_W];
  assign redirect     = pc_sel && (state != BOOT);
  assign resume_state = stall ? HOLD : REQ;

  assign if_req       = (state == REQ) || (state == DRAIN);
  assign inst_valid   = (state == REQ) && !pc_sel && if_ack;
  assign flush_if_id  = redirect;
  assign flush_id_ex  = redirect;
  assign misalign_err = redirect && (br_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      if_addr      <= RESET_PC;
      tgt          <= '0;
      redirect_cnt <= '0;
    end else begin
      if (redirect && !(&redirect_cnt))
        redirect_cnt <= redirect_cnt + 1'b1;

      case (state)
        BOOT: state <= resume_state;
        REQ: begin
          if (pc_sel) begin
            if (if_ack) begin
              if_addr <= tgt_a;
              state   <= resume_state;
            end else begin
              // request already issued on the stale PC; it must complete first
              tgt   <= tgt_a;
              state <= DRAIN;
            end
          end else if (if_ack) begin
            if_addr <= if_addr + PC_W'(4);
            state   <= resume_state;
          end
        end
        HOLD: begin
          if (pc_sel)
            if_addr <= tgt_a;
          state <= resume_state;
        end
        DRAIN: begin
          if (pc_sel)
            tgt <= tgt_a;
          if (if_ack) begin
            if_addr <= pc_sel ? tgt_a : tgt;
            state   <= resume_state;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed scenarios then random traffic, checked each cycle
// against a behavioural fetch model; a second instance exercises counter saturation.
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        pc_sel = 1'b0;
  logic [31:0] br_pc = '0;
  logic        if_ack = 1'b0;

  logic       if_req, inst_valid, flush_if_id, flush_id_ex, misalign_err;
  logic [7:0] if_addr, redirect_cnt;
  logic       if_req2, inst_valid2, flush_if_id2, flush_id_ex2, misalign_err2;
  logic [7:0] if_addr2;
  logic [1:0] redirect_cnt2;

  int checks = 0;
  int errors = 0;

  // behavioural model: booting / issuing / waiting on a wrong-path fetch
  bit         m_boot, m_issuing, m_stale;
  logic [7:0] m_pc, m_tgt, m_cnt;
  int         m_cnt2;

  always #5 clk = ~clk;

  fetch_redirect_ctrl #(.PC_W(8), .RESET_PC(8'h00), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pc_sel(pc_sel), .br_pc(br_pc), .if_ack(if_ack),
    .if_req(if_req), .if_addr(if_addr), .inst_valid(inst_valid), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .misalign_err(misalign_err), .redirect_cnt(redirect_cnt)
  );

  fetch_redirect_ctrl #(.PC_W(8), .RESET_PC(8'h00), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pc_sel(pc_sel), .br_pc(br_pc), .if_ack(if_ack),
    .if_req(if_req2), .if_addr(if_addr2), .inst_valid(inst_valid2), .flush_if_id(flush_if_id2),
    .flush_id_ex(flush_id_ex2), .misalign_err(misalign_err2), .redirect_cnt(redirect_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot = 1'b1; m_issuing = 1'b0; m_stale = 1'b0;
    m_pc = 8'h00; m_tgt = 8'h00; m_cnt = 8'h00; m_cnt2 = 0;
  endtask

  task automatic model_step(input bit s, input bit sel, input logic [31:0] br, input bit ack);
    logic [7:0] ta;
    ta = {br[7:2], 2'b00};
    if (sel && !m_boot) begin
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      if (m_cnt2 < 3) m_cnt2 = m_cnt2 + 1;
    end
    if (m_boot) begin
      m_boot = 1'b0;
      m_issuing = !s;
    end else if (!m_issuing) begin
      if (sel) m_pc = ta;
      m_issuing = !s;
    end else if (!m_stale) begin
      if (ack) begin
        m_pc = sel ? ta : m_pc + 8'd4;
        m_issuing = !s;
      end else if (sel) begin
        m_tgt = ta;
        m_stale = 1'b1;
      end
    end else begin
      if (ack) begin
        m_pc = sel ? ta : m_tgt;
        m_stale = 1'b0;
        m_issuing = !s;
      end else if (sel) begin
        m_tgt = ta;
      end
    end
  endtask

  // entered just after a rising edge; checks mid-cycle, then advances model and clock
  task automatic cycle(input bit s, input bit sel, input logic [31:0] br, input bit ack);
    bit flush;
    stall = s; pc_sel = sel; br_pc = br; if_ack = ack;
    @(negedge clk);
    flush = sel && !m_boot;
    chk("if_req", {31'd0, if_req}, {31'd0, m_issuing});
    chk("if_addr", {24'd0, if_addr}, {24'd0, m_pc});
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_issuing && !m_stale && ack && !sel});
    chk("flush_if_id", {31'd0, flush_if_id}, {31'd0, flush});
    chk("flush_id_ex", {31'd0, flush_id_ex}, {31'd0, flush});
    chk("misalign_err", {31'd0, misalign_err}, {31'd0, flush && (br[1:0] != 2'b00)});
    chk("redirect_cnt", {24'd0, redirect_cnt}, {24'd0, m_cnt});
    chk("redirect_cnt_sat", {30'd0, redirect_cnt2}, m_cnt2);
    model_step(s, sel, br, ack);
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // boot cycle ignores ack and pc_sel
    cycle(0, 1, 32'h0000_0050, 1);
    chk("boot_addr", {24'd0, if_addr}, 32'h00);

    // sequential fetch with wrap
    for (int i = 0; i < 64; i++) cycle(0, 0, 0, 1);
    chk("wrap", {24'd0, if_addr}, 32'h00);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    chk("seq_08", {24'd0, if_addr}, 32'h08);

    // redirect accepted together with ack
    cycle(0, 1, 32'h0000_0040, 1);
    chk("redir_ack_addr", {24'd0, if_addr}, 32'h40);
    chk("redir_ack_cnt", {24'd0, redirect_cnt}, 32'd1);

    // redirect while the stale fetch is outstanding; newest target wins
    cycle(0, 1, 32'h0000_0080, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 32'h0000_0090, 0);
    chk("drain_hold", {24'd0, if_addr}, 32'h40);
    cycle(0, 0, 0, 1);
    chk("drain_target", {24'd0, if_addr}, 32'h90);

    // stall, then misaligned redirect while holding
    cycle(0, 1, 32'h0000_0010, 1);
    cycle(1, 0, 0, 1);
    chk("stall_addr", {24'd0, if_addr}, 32'h14);
    cycle(1, 0, 0, 0);
    cycle(1, 1, 32'h0000_0022, 0);
    chk("hold_redir", {24'd0, if_addr}, 32'h20);
    cycle(0, 0, 0, 0);
    chk("resume_req", {31'd0, if_req}, 32'd1);
    chk("cnt_five", {24'd0, redirect_cnt}, 32'd5);
    chk("cnt_sat", {30'd0, redirect_cnt2}, 32'd3);

    // random traffic
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 9) < 3, $urandom_range(0, 19) < 3, $urandom, $urandom_range(0, 9) < 6);

    // mid-operation reset aborts everything immediately
    cycle(0, 1, 32'h0000_0044, 1);
    cycle(0, 0, 0, 0);
    if_ack = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_if_req", {31'd0, if_req}, 32'd0);
    chk("rst_if_addr", {24'd0, if_addr}, 32'h00);
    chk("rst_cnt", {24'd0, redirect_cnt}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    chk("post_rst_addr", {24'd0, if_addr}, 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
